// File: rtl/bcd_time_counter_if.sv
// Bundle of run/chime/adjust controls and BCD time outputs shared by bcd_time_counter and its driver.
// The adj_min/adj_hour signals exist only when TIME_SET_EN is defined.
interface bcd_time_counter_if;
    logic       run;
    logic       tell_en;
`ifdef TIME_SET_EN
    logic       adj_min;
    logic       adj_hour;
`endif
    logic [7:0] Second;
    logic [7:0] Minute;
    logic [7:0] Hour24;
    logic [7:0] Hour12;
    logic       pm;
    logic       tell;
    logic       tick;

    // Level controls only: run/tell_en/adj_* are sampled on every CP edge, no handshake.
    modport master (
`ifdef TIME_SET_EN
        output adj_min, adj_hour,
`endif
        output run, tell_en,
        input  Second, Minute, Hour24, Hour12, pm, tell, tick
    );

    modport slave (
`ifdef TIME_SET_EN
        input  adj_min, adj_hour,
`endif
        input  run, tell_en,
        output Second, Minute, Hour24, Hour12, pm, tell, tick
    );
endinterface

// File: rtl/bcd_time_counter.sv
// 1 Hz prescaler plus BCD HH:MM:SS timekeeping with 12-hour view and hourly tell window.
// Define TIME_SET_EN to build the adj_min/adj_hour manual time-set logic.
module bcd_time_counter #(
    parameter int unsigned TICK_DIV = 1000
) (
    input logic               CP,
    input logic               nCR,
    bcd_time_counter_if.slave bus
);
    localparam logic [15:0] LP_LAST = 16'(TICK_DIV - 1);

    logic [15:0] r_presc;
    logic [15:0] w_presc_nxt;
    logic        r_tick;
    logic        r_tell;
    logic [7:0]  r_sec;
    logic [7:0]  r_min;
    logic [7:0]  r_hour;
    logic [7:0]  w_sec_nxt;
    logic [7:0]  w_min_nxt;
    logic [7:0]  w_hour_nxt;
    logic [7:0]  w_hour12;
    logic        w_pm;
    logic        w_tick_now;
    logic        w_sec_carry;
    logic        w_min_carry;
    logic        w_min_stb;
    logic        w_hour_stb;

    function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
        if (v == 8'h23)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

`ifdef TIME_SET_EN
    logic r_adj_min_q;
    logic r_adj_hour_q;

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            r_adj_min_q  <= 1'b0;
            r_adj_hour_q <= 1'b0;
        end else begin
            r_adj_min_q  <= bus.adj_min;
            r_adj_hour_q <= bus.adj_hour;
        end
    end

    assign w_min_stb  = bus.adj_min & ~r_adj_min_q;
    assign w_hour_stb = bus.adj_hour & ~r_adj_hour_q;
`else
    assign w_min_stb  = 1'b0;
    assign w_hour_stb = 1'b0;
`endif

    assign w_tick_now  = bus.run & (r_presc == LP_LAST);
    assign w_sec_carry = w_tick_now & (r_sec == 8'h59);
    assign w_min_carry = w_sec_carry & (r_min == 8'h59);

    // A minute strobe overrides the tick for Minute/Second and swallows any hour carry.
    always_comb begin
        w_presc_nxt = r_presc;
        w_sec_nxt   = r_sec;
        w_min_nxt   = r_min;
        w_hour_nxt  = r_hour;
        if (bus.run)
            w_presc_nxt = w_tick_now ? 16'd0 : r_presc + 16'd1;
        if (w_min_stb) begin
            w_presc_nxt = 16'd0;
            w_sec_nxt   = 8'h00;
            w_min_nxt   = bcd_inc60(r_min);
        end else if (w_tick_now) begin
            w_sec_nxt = bcd_inc60(r_sec);
            if (w_sec_carry)
                w_min_nxt = bcd_inc60(r_min);
        end
        if (w_hour_stb || (w_min_carry && !w_min_stb))
            w_hour_nxt = bcd_inc24(r_hour);
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            r_presc <= 16'd0;
            r_tick  <= 1'b0;
            r_sec   <= 8'h00;
            r_min   <= 8'h00;
            r_hour  <= 8'h00;
            r_tell  <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_tick  <= w_tick_now;
            r_sec   <= w_sec_nxt;
            r_min   <= w_min_nxt;
            r_hour  <= w_hour_nxt;
            // Evaluated on the incoming time so tell lines up with 00..15 exactly.
            r_tell  <= bus.tell_en && (w_min_nxt == 8'h00) && (w_sec_nxt <= 8'h15);
        end
    end

    // BCD subtraction of 12: 13-19 and 22-23 need no digit fix-up, 20-21 borrow across the tens digit.
    always_comb begin
        w_pm     = (r_hour >= 8'h12);
        w_hour12 = r_hour;
        case (r_hour)
            8'h00:                                           w_hour12 = 8'h12;
            8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19: w_hour12 = r_hour - 8'h12;
            8'h20, 8'h21:                                    w_hour12 = r_hour - 8'h18;
            8'h22, 8'h23:                                    w_hour12 = r_hour - 8'h12;
            default:                                         w_hour12 = r_hour;
        endcase
    end

    assign bus.Second = r_sec;
    assign bus.Minute = r_min;
    assign bus.Hour24 = r_hour;
    assign bus.Hour12 = w_hour12;
    assign bus.pm     = w_pm;
    assign bus.tell   = r_tell;
    assign bus.tick   = r_tick;
endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter: u_dut (TICK_DIV=4) for reset/run/carry/adjust,
// u_day (TICK_DIV=1) walks a full day for Hour12, tell window and midnight rollover.
module tb_bcd_time_counter;
    logic CP;
    logic nCR;
    int   n_cmp;
    int   n_bad;

    bcd_time_counter_if dut_if();
    bcd_time_counter_if day_if();

    bcd_time_counter #(.TICK_DIV(4)) u_dut (
        .CP  (CP),
        .nCR (nCR),
        .bus (dut_if.slave)
    );

    bcd_time_counter #(.TICK_DIV(1)) u_day (
        .CP  (CP),
        .nCR (nCR),
        .bus (day_if.slave)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge CP);
        n_cmp++;
        if ({dut_if.Hour24, dut_if.Minute, dut_if.Second} !== 24'h000000) begin
            n_bad++;
            $display("FAIL reset_time got %h want 000000", {dut_if.Hour24, dut_if.Minute, dut_if.Second});
        end
        n_cmp++;
        if (dut_if.Hour12 !== 8'h12 || dut_if.pm !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hour12 got %h/%b want 12/0", dut_if.Hour12, dut_if.pm);
        end
        n_cmp++;
        if (dut_if.tell !== 1'b0 || dut_if.tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_tell_tick got %b%b want 00", dut_if.tell, dut_if.tick);
        end
        nCR = 1'b1;
        dut_if.run = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CP);
            n_cmp++;
            if (dut_if.tick !== (i == 4)) begin
                n_bad++;
                $display("FAIL first_tick cycle=%0d got %b want %b", i, dut_if.tick, (i == 4));
            end
        end
        n_cmp++;
        if (dut_if.Second !== 8'h01) begin
            n_bad++;
            $display("FAIL first_second got %h want 01", dut_if.Second);
        end
        // Pulse reset mid-count (prescaler at 2) and look before the next edge.
        repeat (2) @(negedge CP);
        nCR = 1'b0;
        #1;
        n_cmp++;
        if ({dut_if.Hour24, dut_if.Minute, dut_if.Second, dut_if.Hour12, dut_if.pm, dut_if.tell} !== {32'h00000012, 2'b00}) begin
            n_bad++;
            $display("FAIL async_reset got %h %h %h %h %b %b want 00 00 00 12 0 0",
                     dut_if.Hour24, dut_if.Minute, dut_if.Second, dut_if.Hour12, dut_if.pm, dut_if.tell);
        end
        @(negedge CP);
        nCR = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CP);
            n_cmp++;
            if (dut_if.tick !== (i == 4)) begin
                n_bad++;
                $display("FAIL tick_after_reset cycle=%0d got %b want %b", i, dut_if.tick, (i == 4));
            end
        end
    endtask

    task automatic test_run_freeze();
        int seen;
        seen = 0;
        repeat (2) @(negedge CP);
        dut_if.run = 1'b0;
        repeat (40) begin
            @(negedge CP);
            if (dut_if.tick !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL freeze_tick got %0d ticks want 0", seen);
        end
        n_cmp++;
        if (dut_if.Second !== 8'h01) begin
            n_bad++;
            $display("FAIL freeze_second got %h want 01", dut_if.Second);
        end
        dut_if.run = 1'b1;
        @(negedge CP);
        n_cmp++;
        if (dut_if.tick !== 1'b0) begin
            n_bad++;
            $display("FAIL resume_early got %b want 0", dut_if.tick);
        end
        @(negedge CP);
        n_cmp++;
        if (dut_if.tick !== 1'b1 || dut_if.Second !== 8'h02) begin
            n_bad++;
            $display("FAIL resume_tick got %b/%h want 1/02", dut_if.tick, dut_if.Second);
        end
    endtask

    task automatic test_minute_carry();
        repeat (228) @(negedge CP);
        n_cmp++;
        if ({dut_if.Hour24, dut_if.Minute, dut_if.Second} !== 24'h000059) begin
            n_bad++;
            $display("FAIL pre_carry got %h want 000059", {dut_if.Hour24, dut_if.Minute, dut_if.Second});
        end
        repeat (4) @(negedge CP);
        n_cmp++;
        if ({dut_if.Hour24, dut_if.Minute, dut_if.Second} !== 24'h000100) begin
            n_bad++;
            $display("FAIL minute_carry got %h want 000100", {dut_if.Hour24, dut_if.Minute, dut_if.Second});
        end
    endtask

`ifdef TIME_SET_EN
    task automatic pulse_min();
        dut_if.adj_min = 1'b1;
        @(negedge CP);
        dut_if.adj_min = 1'b0;
        @(negedge CP);
    endtask

    task automatic test_adjust();
        dut_if.run = 1'b0;
        repeat (58) pulse_min();
        n_cmp++;
        if ({dut_if.Hour24, dut_if.Minute, dut_if.Second} !== 24'h005900) begin
            n_bad++;
            $display("FAIL adj_min_steps got %h want 005900", {dut_if.Hour24, dut_if.Minute, dut_if.Second});
        end
        dut_if.run = 1'b1;
        repeat (236) @(negedge CP);
        n_cmp++;
        if ({dut_if.Hour24, dut_if.Minute, dut_if.Second} !== 24'h005959) begin
            n_bad++;
            $display("FAIL adj_pre_collide got %h want 005959", {dut_if.Hour24, dut_if.Minute, dut_if.Second});
        end
        repeat (3) @(negedge CP);
        dut_if.adj_min = 1'b1;
        @(negedge CP);
        n_cmp++;
        if ({dut_if.Hour24, dut_if.Minute, dut_if.Second} !== 24'h000000) begin
            n_bad++;
            $display("FAIL adj_min_collide got %h want 000000", {dut_if.Hour24, dut_if.Minute, dut_if.Second});
        end
        dut_if.adj_min = 1'b0;
        dut_if.run = 1'b0;
        @(negedge CP);
        dut_if.adj_hour = 1'b1;
        @(negedge CP);
        n_cmp++;
        if ({dut_if.Hour24, dut_if.Minute, dut_if.Second} !== 24'h010000) begin
            n_bad++;
            $display("FAIL adj_hour got %h want 010000", {dut_if.Hour24, dut_if.Minute, dut_if.Second});
        end
        dut_if.adj_hour = 1'b0;
        @(negedge CP);
        dut_if.adj_min = 1'b1;
        dut_if.adj_hour = 1'b1;
        @(negedge CP);
        n_cmp++;
        if ({dut_if.Hour24, dut_if.Minute, dut_if.Second} !== 24'h020100) begin
            n_bad++;
            $display("FAIL adj_both got %h want 020100", {dut_if.Hour24, dut_if.Minute, dut_if.Second});
        end
        dut_if.adj_min = 1'b0;
        dut_if.adj_hour = 1'b0;
        @(negedge CP);
        repeat (58) pulse_min();
        dut_if.run = 1'b1;
        repeat (239) @(negedge CP);
        dut_if.adj_hour = 1'b1;
        @(negedge CP);
        n_cmp++;
        if ({dut_if.Hour24, dut_if.Minute, dut_if.Second} !== 24'h030000) begin
            n_bad++;
            $display("FAIL adj_hour_collide got %h want 030000", {dut_if.Hour24, dut_if.Minute, dut_if.Second});
        end
        dut_if.adj_hour = 1'b0;
        dut_if.run = 1'b0;
        @(negedge CP);
    endtask
`endif

    task automatic test_full_day();
        int          t;
        int          h;
        int          h12;
        int          errs;
        logic [23:0] exp_time;
        logic [7:0]  exp_h12;
        errs = 0;
        day_if.tell_en = 1'b1;
        day_if.run = 1'b1;
        for (int k = 1; k <= 86401 && errs < 10; k++) begin
            @(negedge CP);
            t = k % 86400;
            h = t / 3600;
            exp_time = {to_bcd(h), to_bcd((t / 60) % 60), to_bcd(t % 60)};
            n_cmp++;
            if ({day_if.Hour24, day_if.Minute, day_if.Second} !== exp_time) begin
                n_bad++;
                errs++;
                $display("FAIL day_time t=%0d got %h want %h", t, {day_if.Hour24, day_if.Minute, day_if.Second}, exp_time);
            end
            if (t % 3600 == 0 || t == 86399) begin
                h12 = (h % 12 == 0) ? 12 : h % 12;
                exp_h12 = to_bcd(h12);
                n_cmp++;
                if (day_if.Hour12 !== exp_h12 || day_if.pm !== (h >= 12)) begin
                    n_bad++;
                    errs++;
                    $display("FAIL hour12 h24=%0d got %h/%b want %h/%b", h, day_if.Hour12, day_if.pm, exp_h12, (h >= 12));
                end
            end
            if (k == 1) begin
                n_cmp++;
                if (day_if.tick !== 1'b1) begin
                    n_bad++;
                    $display("FAIL div1_tick got %b want 1", day_if.tick);
                end
            end
            if (t == 53999 || t == 54000 || t == 54015 || t == 54016 || t == 57600 || t == 57606 || k == 86400) begin
                n_cmp++;
                if (day_if.tell !== (t != 53999 && t != 54016 && t != 57606)) begin
                    n_bad++;
                    $display("FAIL tell t=%0d got %b want %b", t, day_if.tell, (t != 53999 && t != 54016 && t != 57606));
                end
            end
            if (t == 57605) day_if.tell_en = 1'b0;
            if (t == 60000) day_if.tell_en = 1'b1;
        end
        day_if.run = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nCR = 1'b1;
        dut_if.run = 1'b0;
        dut_if.tell_en = 1'b0;
        day_if.run = 1'b0;
        day_if.tell_en = 1'b0;
`ifdef TIME_SET_EN
        dut_if.adj_min = 1'b0;
        dut_if.adj_hour = 1'b0;
        day_if.adj_min = 1'b0;
        day_if.adj_hour = 1'b0;
`endif
        #2 nCR = 1'b0;
        test_reset();
        test_run_freeze();
        test_minute_carry();
`ifdef TIME_SET_EN
        test_adjust();
`endif
        test_full_day();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
